// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and grant IDs.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive MEM grants taken while IF was waiting.
// force_if_o tells the arbiter that IF must win the next grant it competes for.
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic grant_if_i,
    input  logic grant_dm_i,
    input  logic if_req_i,
    output logic force_if_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear when IF is served or nobody was starved, else saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_if_i) begin
            cnt_d = '0;
        end else if (grant_dm_i) begin
            if (!if_req_i) begin
                cnt_d = '0;
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and data access (MEM).
// Each access runs IDLE -> BUSY -> RESP; stall_o freezes the pipeline until it completes.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    arb_state_e        state_q;
    logic              gnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;

    logic grant_en;
    logic pick_dm;
    logic force_if;

    // MEM normally wins (older instruction) unless IF has been starved long enough.
    assign grant_en = (state_q == ARB_IDLE) && start_i && (if_req_i || dm_req_i);
    assign pick_dm  = dm_req_i && !(force_if && if_req_i);

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .grant_if_i (grant_en && !pick_dm),
        .grant_dm_i (grant_en && pick_dm),
        .if_req_i   (if_req_i),
        .force_if_o (force_if)
    );

    // Arbiter FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_en) begin
                        gnt_q       <= pick_dm ? GNT_DM : GNT_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= pick_dm && dm_we_i;
                        mem_addr_q  <= pick_dm ? dm_addr_i : if_addr_i;
                        mem_wdata_q <= pick_dm ? dm_wdata_i : '0;
                        state_q     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (gnt_q == GNT_DM) begin
                            dm_ready_q <= 1'b1;
                            // Writes leave the previously read data visible.
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata_i;
                            end
                        end else begin
                            if_ready_q <= 1'b1;
                            if_data_q  <= mem_rdata_i;
                        end
                        state_q <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_ready_o  = dm_ready_q;

    // A requester is stalled until its own ready pulse.
    assign stall_o = (if_req_i && !if_ready_q) || (dm_req_i && !dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses plus hand-written corner sequences,
// checked by a grant/response scoreboard against a small memory responder.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_i, start_i;
    logic        if_req_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        if_ready_o, dm_ready_o, mem_req_o, mem_we_o, mem_ack_i, stall_o;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    exp_t        cur;
    bit          have_cur = 1'b0;
    logic [31:0] dm_shadow = '0;
    logic        req_prev = 1'b0;

    // Memory responder
    logic [31:0] mem_model [logic [31:0]];
    bit          auto_ack = 1'b1;
    logic        ack_auto = 1'b0;
    logic        ack_man = 1'b0;
    logic [31:0] rdata_auto = '0;
    int          lat_cfg = 1;
    int          wait_cnt = 0;

    assign mem_ack_i   = auto_ack ? ack_auto : ack_man;
    assign mem_rdata_i = rdata_auto;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ack lat_cfg cycles after the first BUSY cycle.
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (wait_cnt == lat_cfg) begin
                ack_auto   = 1'b1;
                rdata_auto = model_rd(mem_addr_o);
            end else begin
                ack_auto = 1'b0;
            end
            wait_cnt++;
        end else begin
            ack_auto = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard: check each grant and each ready pulse against the expected queue.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (mem_req_o && !req_prev) begin
                if (exp_q.size() == 0) begin
                    chk("grant_expected", 32'd0, 32'd1);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("grant_addr", mem_addr_o, cur.addr);
                    chk("grant_we", 32'(mem_we_o), 32'(cur.we));
                    if (cur.we) chk("grant_wdata", mem_wdata_o, cur.wdata);
                end
            end
            if (if_ready_o || dm_ready_o) begin
                chk("ready_has_grant", 32'(have_cur), 32'd1);
                chk("ready_exclusive", 32'(if_ready_o && dm_ready_o), 32'd0);
                chk("ready_port", 32'(dm_ready_o), 32'(cur.is_dm));
                chk("ready_data", cur.is_dm ? dm_rdata_o : if_data_o, cur.data);
                have_cur = 1'b0;
            end
        end
        req_prev = mem_req_o;
    end

    task automatic push_exp(input bit is_dm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.is_dm = is_dm;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.data  = (is_dm && we) ? dm_shadow : rdata;
        if (is_dm && !we) dm_shadow = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input bit is_dm, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (is_dm ? dm_ready_o : if_ready_o) seen = 1'b1;
            else chk({name, "_stall_wait"}, 32'(stall_o), 32'd1);
        end
        chk({name, "_ready_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_access(input vec_t v, input string name);
        lat_cfg = v.lat;
        mem_model[v.addr] = v.rdata;
        push_exp(v.is_dm, v.we, v.addr, v.wdata, v.rdata);
        @(negedge clk);
        if (v.is_dm) begin
            dm_req_i   = 1'b1;
            dm_we_i    = v.we;
            dm_addr_i  = v.addr;
            dm_wdata_i = v.wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end
        wait_ready(v.is_dm, name);
        chk({name, "_stall_at_ready"}, 32'(stall_o), 32'd0);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int   nrdy;
        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h8C010004, 2};
        vecs[1] = '{1'b1, 1'b0, 32'h80,  32'h0,        32'h00000055, 1};
        vecs[2] = '{1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 32'h11111111, 1};
        vecs[3] = '{1'b0, 1'b0, 32'h14,  32'h0,        32'h12345678, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h108, 32'hFFFF0000, 32'hCAFEF00D, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h10C, 32'h0,        32'h22222222, 0};

        rst_i = 1'b1; start_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {27'd0, mem_req_o, mem_we_o, if_ready_o, dm_ready_o, stall_o}, 32'd0);
        chk("reset_if_data", if_data_o, 32'd0);
        chk("reset_dm_rdata", dm_rdata_o, 32'd0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);
        chk("reset_mem_wdata", mem_wdata_o, 32'd0);
        start_i = 1'b1;

        // Single accesses: IF read, MEM read, MEM write keeps rdata, zero and long latency.
        for (int i = 0; i < 6; i++) do_access(vecs[i], $sformatf("vec%0d", i));

        // IF and MEM raised together: MEM first, then IF.
        lat_cfg = 1;
        mem_model[32'h100] = 32'hA0A0_0100;
        mem_model[32'h20]  = 32'hB0B0_0020;
        push_exp(1'b1, 1'b0, 32'h100, 32'h0, 32'hA0A0_0100);
        push_exp(1'b0, 1'b0, 32'h20, 32'h0, 32'hB0B0_0020);
        @(negedge clk);
        dm_req_i = 1'b1; dm_addr_i = 32'h100; if_req_i = 1'b1; if_addr_i = 32'h20;
        wait_ready(1'b1, "both_dm");
        dm_req_i = 1'b0;
        wait_ready(1'b0, "both_if");
        chk("both_stall_at_ready", 32'(stall_o), 32'd0);
        if_req_i = 1'b0;

        // Both held: starvation limit 2 gives MEM, MEM, IF, MEM, MEM, IF.
        lat_cfg = 0;
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) push_exp(1'b0, 1'b0, 32'h300, 32'h0, model_rd(32'h300));
            else push_exp(1'b1, 1'b0, 32'h200, 32'h0, model_rd(32'h200));
        end
        @(negedge clk);
        dm_req_i = 1'b1; dm_addr_i = 32'h200; if_req_i = 1'b1; if_addr_i = 32'h300;
        nrdy = 0;
        for (int c = 0; c < 100 && nrdy < 6; c++) begin
            @(negedge clk);
            if (if_ready_o || dm_ready_o) begin
                nrdy++;
                if (nrdy == 6) begin
                    chk("starve_last_is_if", 32'(if_ready_o), 32'd1);
                    if_req_i = 1'b0;
                    dm_req_i = 1'b0;
                end
            end
        end
        chk("starve_ready_count", 32'(nrdy), 32'd6);

        // start_i low blocks grants; start_i dropping mid-access does not abort it.
        lat_cfg = 1;
        push_exp(1'b0, 1'b0, 32'h50, 32'h0, model_rd(32'h50));
        @(negedge clk);
        start_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h50;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("nostart_mem_req", 32'(mem_req_o), 32'd0);
            chk("nostart_stall", 32'(stall_o), 32'd1);
        end
        start_i = 1'b1;
        @(negedge clk);
        chk("start_grant", 32'(mem_req_o), 32'd1);
        start_i = 1'b0;
        wait_ready(1'b0, "start_low_busy");
        if_req_i = 1'b0;
        start_i = 1'b1;

        // Reset in the 2nd BUSY cycle, late ack afterwards is ignored.
        auto_ack = 1'b0;
        push_exp(1'b0, 1'b0, 32'h40, 32'h0, model_rd(32'h40));
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h40;
        @(negedge clk);
        chk("rst_busy1", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        rst_i = 1'b1; if_req_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0; ack_man = 1'b1;
        chk("rst_ctrl", {27'd0, mem_req_o, mem_we_o, if_ready_o, dm_ready_o, stall_o}, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        @(negedge clk);
        ack_man = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("late_ack_ctrl", {29'd0, mem_req_o, if_ready_o, dm_ready_o}, 32'd0);
            chk("late_ack_if_data", if_data_o, 32'd0);
            @(negedge clk);
        end
        have_cur  = 1'b0;
        dm_shadow = '0;
        auto_ack  = 1'b1;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
